// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode LED sequencer.
// Holds the sequencer state enum and the output bundle that is driven
// while idle and while held in reset.
package barcode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_ON   = 2'd2,
        ST_OFF  = 2'd3
    } state_e;

    // Registered output bundle of the sequencer
    typedef struct packed {
        logic       pwm;
        logic [3:0] cbit;
        logic       ir500;
        logic       busy;
        logic       done;
    } led_out_t;

    localparam logic       IDLE_PWM   = 1'b0;
    localparam logic [3:0] IDLE_CBIT  = 4'd0;
    localparam logic       IDLE_IR500 = 1'b0;
    localparam logic       IDLE_BUSY  = 1'b0;
    localparam logic       IDLE_DONE  = 1'b0;

    // Value of every output in IDLE and in reset
    localparam led_out_t LED_OUT_IDLE = '{
        pwm:   IDLE_PWM,
        cbit:  IDLE_CBIT,
        ir500: IDLE_IR500,
        busy:  IDLE_BUSY,
        done:  IDLE_DONE
    };

endpackage

// File: rtl/barcode_pwm_gen.sv
// Period/on-time counter for the barcode LED PWM.
// While run is high the counter walks 0..period-1 and wraps; on_end marks
// the last high cycle of a pulse and pulse_end the last cycle of the period.
// When run is low the counter sits at zero so a pulse always starts clean.
module barcode_pwm_gen
    import barcode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] on_time,
    output logic             on_end,
    output logic             pulse_end
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the compare against the full-scale period cannot wrap
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign on_end    = run && (cnt_inc == {1'b0, on_time});
    assign pulse_end = run && (cnt_inc == {1'b0, period});

    // Next count: advance while running, wrap at the end of the period
    always_comb begin
        cnt_d = '0;
        if (run && !pulse_end) begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/barcode_led_seq.sv
// Barcode LED burst sequencer.
// Captures a burst configuration on start, optionally soft-starts the LED
// current code, then emits cfg_pulses PWM pulses (or runs until abort when
// cfg_pulses is zero). abort or poc drop everything back to IDLE.
// Build option: define BARCODE_SOFTSTART_EN to ramp the current code from 0
// to the target in RAMP_DIV-cycle steps before the first pulse; otherwise
// the target code is applied on the start edge and pulsing begins at once.
module barcode_led_seq
    import barcode_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int RAMP_DIV = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             poc,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic [3:0]       cfg_current,
    input  logic             cfg_ir500,
    output logic             barcode_pwm,
    output logic [3:0]       cbit_barcode,
    output logic             cbit_ir500,
    output logic             busy,
    output logic             done
);

    localparam int             RW        = $clog2(RAMP_DIV + 1);
    localparam logic [RW-1:0]  RAMP_LAST = RW'(RAMP_DIV - 1);

    state_e           state_q,   state_d;
    led_out_t         out_q,     out_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] on_q,      on_d;
    logic [CNT_W-1:0] pulses_q,  pulses_d;
    logic [3:0]       current_q, current_d;
    logic [CNT_W-1:0] pcnt_q,    pcnt_d;
    logic [RW-1:0]    rcnt_q,    rcnt_d;

    logic       cfg_ok;
    logic       accept;
    logic       kill;
    logic       run;
    logic       on_end;
    logic       pulse_end;
    logic [3:0] cbit_step;

    // A burst needs a non-empty period with a strictly shorter high time
    assign cfg_ok = (cfg_period != '0) && (cfg_on != '0) && (cfg_on < cfg_period);
    assign accept = (state_q == ST_IDLE) && start && !abort && !poc && cfg_ok;
    assign kill   = (state_q != ST_IDLE) && (abort || poc);
    assign run    = (state_q == ST_ON) || (state_q == ST_OFF);

    barcode_pwm_gen #(
        .CNT_W (CNT_W)
    ) u_pwm_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .period    (period_q),
        .on_time   (on_q),
        .on_end    (on_end),
        .pulse_end (pulse_end)
    );

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_d.done = 1'b0;
        period_d  = period_q;
        on_d      = on_q;
        pulses_d  = pulses_q;
        current_d = current_q;
        pcnt_d    = pcnt_q;
        rcnt_d    = rcnt_q;
        cbit_step = out_q.cbit + 4'd1;

        case (state_q)
            ST_IDLE: begin
                out_d = LED_OUT_IDLE;
                if (accept) begin
                    period_d    = cfg_period;
                    on_d        = cfg_on;
                    pulses_d    = cfg_pulses;
                    current_d   = cfg_current;
                    pcnt_d      = '0;
                    rcnt_d      = '0;
                    out_d.busy  = 1'b1;
                    out_d.ir500 = cfg_ir500;
`ifdef BARCODE_SOFTSTART_EN
                    out_d.cbit  = 4'd0;
                    if (cfg_current == 4'd0) begin
                        state_d   = ST_ON;
                        out_d.pwm = 1'b1;
                    end else begin
                        state_d   = ST_RAMP;
                    end
`else
                    out_d.cbit  = cfg_current;
                    out_d.pwm   = 1'b1;
                    state_d     = ST_ON;
`endif
                end
            end

            ST_RAMP: begin
                out_d.pwm = 1'b0;
                if (rcnt_q == RAMP_LAST) begin
                    rcnt_d     = '0;
                    out_d.cbit = cbit_step;
                    if (cbit_step == current_q) begin
                        state_d   = ST_ON;
                        out_d.pwm = 1'b1;
                    end
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end

            ST_ON: begin
                if (on_end) begin
                    state_d   = ST_OFF;
                    out_d.pwm = 1'b0;
                    if (pcnt_q != '1) begin
                        pcnt_d = pcnt_q + CNT_W'(1);
                    end
                end
            end

            ST_OFF: begin
                if (pulse_end) begin
                    if ((pulses_q != '0) && (pcnt_q == pulses_q)) begin
                        state_d    = ST_IDLE;
                        out_d      = LED_OUT_IDLE;
                        out_d.done = 1'b1;
                    end else begin
                        state_d   = ST_ON;
                        out_d.pwm = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                out_d   = LED_OUT_IDLE;
            end
        endcase

        // abort / pad power loss override everything, no done
        if (kill) begin
            state_d = ST_IDLE;
            out_d   = LED_OUT_IDLE;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_q     <= LED_OUT_IDLE;
            period_q  <= '0;
            on_q      <= '0;
            pulses_q  <= '0;
            current_q <= '0;
            pcnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            period_q  <= period_d;
            on_q      <= on_d;
            pulses_q  <= pulses_d;
            current_q <= current_d;
            pcnt_q    <= pcnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign barcode_pwm  = out_q.pwm;
    assign cbit_barcode = out_q.cbit;
    assign cbit_ir500   = out_q.ir500;
    assign busy         = out_q.busy;
    assign done         = out_q.done;

endmodule

// File: tb/tb_barcode_led_seq.sv
// Self-checking bench for barcode_led_seq.
// Expected output traces are generated from the burst description
// (ramp steps, then period-long pulses, then a done cycle) and compared
// cycle by cycle; follows BARCODE_SOFTSTART_EN like the design.
module tb_barcode_led_seq;

    localparam int CNT_W    = 16;
    localparam int RAMP_DIV = 4;
`ifdef BARCODE_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             poc = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_on = '0;
    logic [CNT_W-1:0] cfg_pulses = '0;
    logic [3:0]       cfg_current = '0;
    logic             cfg_ir500 = 1'b0;
    logic             barcode_pwm;
    logic [3:0]       cbit_barcode;
    logic             cbit_ir500;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pwm;
        logic [3:0] cbit;
        logic       ir;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int period;
        int on;
        int pulses;
        int cur;
        bit ab;
        bit pc;
        bit exp_busy;
    } vec_t;

    obs_t exp_q[$];

    barcode_led_seq #(
        .CNT_W    (CNT_W),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .poc          (poc),
        .cfg_period   (cfg_period),
        .cfg_on       (cfg_on),
        .cfg_pulses   (cfg_pulses),
        .cfg_current  (cfg_current),
        .cfg_ir500    (cfg_ir500),
        .barcode_pwm  (barcode_pwm),
        .cbit_barcode (cbit_barcode),
        .cbit_ir500   (cbit_ir500),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input bit pwm, input int cbit, input bit ir,
                                input bit bsy, input bit dn);
        obs_t o;
        o.pwm  = pwm;
        o.cbit = 4'(cbit);
        o.ir   = ir;
        o.busy = bsy;
        o.done = dn;
        return o;
    endfunction

    function automatic obs_t got();
        obs_t o;
        o.pwm  = barcode_pwm;
        o.cbit = cbit_barcode;
        o.ir   = cbit_ir500;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    task automatic check(input string name, input int idx, input obs_t e);
        obs_t g;
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got pwm=%b cbit=%0d ir=%b busy=%b done=%b, expected pwm=%b cbit=%0d ir=%b busy=%b done=%b",
                     name, idx, g.pwm, g.cbit, g.ir, g.busy, g.done,
                     e.pwm, e.cbit, e.ir, e.busy, e.done);
        end
    endtask

    // Cycles spent ramping before the first pulse
    function automatic int ramp_len(input int cur);
        return SOFT ? cur * RAMP_DIV : 0;
    endfunction

    // Expected trace starting with the first cycle after the start edge
    task automatic build(input int period, input int on, input int pulses,
                         input int cur, input bit ir, input int gen_pulses);
        int n;
        exp_q.delete();
        if (SOFT) begin
            for (int k = 0; k < cur; k++)
                for (int r = 0; r < RAMP_DIV; r++)
                    exp_q.push_back(mk(1'b0, k, ir, 1'b1, 1'b0));
        end
        n = (pulses == 0) ? gen_pulses : pulses;
        for (int p = 0; p < n; p++)
            for (int c = 0; c < period; c++)
                exp_q.push_back(mk(c < on, cur, ir, 1'b1, 1'b0));
        if (pulses != 0) exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    // One burst: kill_at = trace index after which abort (kind 0) or poc
    // (kind 1) is raised, restart_at = index after which start is re-pulsed
    task automatic run_burst(input string name, input int period, input int on,
                             input int pulses, input int cur, input bit ir,
                             input int gen_pulses, input int kill_at,
                             input int kill_kind, input int restart_at);
        cfg_period  = CNT_W'(period);
        cfg_on      = CNT_W'(on);
        cfg_pulses  = CNT_W'(pulses);
        cfg_current = 4'(cur);
        cfg_ir500   = ir;
        build(period, on, pulses, cur, ir, gen_pulses);
        if (kill_at >= 0) begin
            while (exp_q.size() > kill_at + 1) void'(exp_q.pop_back());
            exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        end
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start = 1'b0;
            check(name, i, exp_q[i]);
            // scramble live config: shadows must hold the captured values
            cfg_period  = CNT_W'($urandom_range(0, 20));
            cfg_on      = CNT_W'($urandom_range(0, 20));
            cfg_pulses  = CNT_W'($urandom_range(0, 5));
            cfg_current = 4'($urandom);
            cfg_ir500   = 1'($urandom);
            if (i == kill_at) begin
                if (kill_kind == 0) abort = 1'b1;
                else poc = 1'b1;
            end
            if (i == restart_at) start = 1'b1;
        end
        abort = 1'b0;
        poc   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[8];
        int   bl;
        int   ka;
        int   p, o, n, c;

        tbl[0] = '{10, 3, 4, 8, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{10, 10, 1, 3, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{0, 0, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{5, 0, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{4, 7, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{10, 3, 4, 8, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{10, 3, 4, 8, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{2, 1, 1, 0, 1'b0, 1'b0, 1'b1};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("reset", 0, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", 0, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));

        // start acceptance table
        for (int i = 0; i < 8; i++) begin
            cfg_period  = CNT_W'(tbl[i].period);
            cfg_on      = CNT_W'(tbl[i].on);
            cfg_pulses  = CNT_W'(tbl[i].pulses);
            cfg_current = 4'(tbl[i].cur);
            cfg_ir500   = 1'b1;
            abort       = tbl[i].ab;
            poc         = tbl[i].pc;
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            poc   = 1'b0;
            checks++;
            if ({busy, done, cbit_ir500} !== {tbl[i].exp_busy, 1'b0, tbl[i].exp_busy}) begin
                errors++;
                $display("FAIL accept[%0d]: got busy=%b done=%b ir=%b, expected busy=%b done=0 ir=%b",
                         i, busy, done, cbit_ir500, tbl[i].exp_busy, tbl[i].exp_busy);
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("accept_idle", i, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        end

        // nominal burst, ramp then four pulses
        run_burst("nominal", 10, 3, 4, 8, 1'b1, 0, -1, 0, -1);
        // target current 0 skips any ramp
        run_burst("zero_cur", 6, 2, 2, 0, 1'b0, 0, -1, 0, -1);
        // continuous, abort in the second ON cycle of the sixth pulse
        run_burst("cont_abort", 10, 3, 0, 5, 1'b1, 7, ramp_len(5) + 51, 0, -1);
        // poc rises early (inside the ramp when soft start is built in)
        run_burst("poc_ramp", 10, 3, 4, 8, 1'b0, 0, 5, 1, -1);
        // second start mid-burst is ignored
        run_burst("restart", 10, 3, 3, 2, 1'b1, 0, -1, 0, ramp_len(2) + 15);

        // start while poc high is ignored
        poc = 1'b1;
        cfg_period = 10; cfg_on = 3; cfg_pulses = 2; cfg_current = 4;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("poc_start", i, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        end
        poc = 1'b0;

        // asynchronous reset mid-OFF, no resume after release
        cfg_period = 10; cfg_on = 3; cfg_pulses = 0; cfg_current = 2; cfg_ir500 = 1'b1;
        build(10, 3, 0, 2, 1'b1, 2);
        start = 1'b1;
        for (int i = 0; i <= ramp_len(2) + 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("pre_reset", i, exp_q[i]);
        end
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset", i, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        end

        // randomized bursts
        for (int t = 0; t < 25; t++) begin
            p  = $urandom_range(2, 12);
            o  = $urandom_range(1, p - 1);
            n  = $urandom_range(0, 3);
            c  = $urandom_range(0, 15);
            bl = ramp_len(c) + ((n == 0) ? 3 : n) * p;
            if (n == 0 || $urandom_range(0, 2) == 0) ka = $urandom_range(0, bl - 1);
            else ka = -1;
            run_burst("random", p, o, n, c, 1'($urandom), 3, ka,
                      int'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
